// File: rtl/ex_mem_flag_stage.sv
// EX/MEM register: captures ALU result and flags, owns the Z/V/N flag register, resolves branches.
// Optional OVF_TRAP_EN adds ovf_trap and suppresses the write-back of overflowing flag-setters.
module ex_mem_flag_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int RD_W       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_overflow,
  input  logic                  alu_negative,
  input  logic                  set_flags,
  input  logic                  is_branch,
  input  logic [2:0]            br_cond,
  input  logic [DATA_WIDTH-1:0] br_target,
  input  logic [RD_W-1:0]       rd,
  input  logic                  reg_write,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [RD_W-1:0]       out_rd,
  output logic                  out_reg_write,
  output logic                  flag_z,
  output logic                  flag_v,
  output logic                  flag_n,
  output logic                  branch_taken,
  output logic [DATA_WIDTH-1:0] branch_pc
`ifdef OVF_TRAP_EN
  ,
  output logic                  ovf_trap
`endif
);

  logic accept;
  logic upd_flags;
  logic cond_met;
  logic kill_wb;

  assign accept    = in_valid & ~stall & ~flush;
  assign upd_flags = set_flags & ~is_branch;

  // Branches test the flags committed before this edge; no forwarding.
  always_comb begin
    cond_met = 1'b0;
    unique case (br_cond)
      3'b000: cond_met = 1'b1;
      3'b001: cond_met = flag_z;
      3'b010: cond_met = ~flag_z;
      3'b011: cond_met = flag_n ^ flag_v;
      3'b100: cond_met = ~(flag_n ^ flag_v);
      3'b101: cond_met = flag_v;
      3'b110: cond_met = ~flag_v;
      3'b111: cond_met = 1'b0;
    endcase
  end

`ifdef OVF_TRAP_EN
  assign kill_wb = upd_flags & alu_overflow;
`else
  assign kill_wb = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      flag_z        <= 1'b0;
      flag_v        <= 1'b0;
      flag_n        <= 1'b0;
      branch_taken  <= 1'b0;
      branch_pc     <= '0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
      branch_taken  <= 1'b0;
    end else if (stall) begin
      branch_taken  <= 1'b0;
    end else if (in_valid) begin
      out_valid     <= 1'b1;
      out_result    <= alu_result;
      out_rd        <= rd;
      out_reg_write <= reg_write & ~kill_wb;
      if (upd_flags) begin
        flag_z <= alu_zero;
        flag_v <= alu_overflow;
        flag_n <= alu_negative;
      end
      branch_taken  <= is_branch & cond_met;
      if (is_branch & cond_met)
        branch_pc <= br_target;
    end else begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
      branch_taken  <= 1'b0;
    end
  end

`ifdef OVF_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst)
      ovf_trap <= 1'b0;
    else
      ovf_trap <= accept & kill_wb;
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
